// File: rtl/seg_display_scan_if.sv
// seg_display_scan_if: scan inputs and display outputs of the seven-segment driver
interface seg_display_scan_if #(parameter int NUM_DIGITS = 4);
  logic                    seg_tick_in;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic [2:0]              digit_idx;
  logic                    frame_done;
  modport master (output seg_tick_in, value, dp_mask, blank, input an, seg, dp, digit_idx, frame_done);
  modport slave (input seg_tick_in, value, dp_mask, blank, output an, seg, dp, digit_idx, frame_done);
endinterface

// File: rtl/seg_display_scan.sv
// seg_display_scan: multiplexed hex display scanner; SEG_LEADING_ZERO_BLANK_EN enables leading-zero blanking
module seg_display_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst_n,
  seg_display_scan_if.slave bus
);
  localparam int W = 4 * NUM_DIGITS;
  logic                  tick_prev, blank_r, dp_r, fd;
  logic [2:0]            idx, nidx;
  logic [W-1:0]          sh_v, src_v;
  logic [NUM_DIGITS-1:0] sh_d, src_d, an_oh, an_n, an_act;
  logic [6:0]            seg_r, seg_n;
  logic [3:0]            nib;
  logic                  advance, last, wrap, dpl, lz;
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'h3F; 4'h1: dec = 7'h06; 4'h2: dec = 7'h5B; 4'h3: dec = 7'h4F;
      4'h4: dec = 7'h66; 4'h5: dec = 7'h6D; 4'h6: dec = 7'h7D; 4'h7: dec = 7'h07;
      4'h8: dec = 7'h7F; 4'h9: dec = 7'h6F; 4'hA: dec = 7'h77; 4'hB: dec = 7'h7C;
      4'hC: dec = 7'h39; 4'hD: dec = 7'h5E; 4'hE: dec = 7'h79; default: dec = 7'h71;
    endcase
  endfunction
  // on wrap the freshly sampled value/dp_mask bypass the shadow registers
  always_comb begin
    advance = bus.seg_tick_in != tick_prev;
    last    = idx == 3'(NUM_DIGITS - 1);
    wrap    = advance && last;
    nidx    = !advance ? idx : last ? 3'd0 : idx + 3'd1;
    src_v   = wrap ? bus.value : sh_v;
    src_d   = wrap ? bus.dp_mask : sh_d;
    nib     = 4'(src_v >> {nidx, 2'b00});
    dpl     = 1'(src_d >> nidx);
  end
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [W-1:0] hi;
  assign hi = src_v >> {nidx, 2'b00};
  assign lz = nidx != 3'd0 && hi == '0;
`else
  assign lz = 1'b0;
`endif
  always_comb begin
    seg_n  = lz ? 7'h00 : dec(nib);
    an_n   = lz && !dpl ? '0 : NUM_DIGITS'(1) << nidx;
    an_act = blank_r ? '0 : an_oh;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tick_prev <= 1'b0;
      blank_r   <= 1'b0;
      fd        <= 1'b0;
      idx       <= 3'(NUM_DIGITS - 1);
      sh_v      <= '0;
      sh_d      <= '0;
      an_oh     <= '0;
      seg_r     <= '0;
      dp_r      <= 1'b0;
    end else begin
      tick_prev <= bus.seg_tick_in;
      blank_r   <= bus.blank;
      fd        <= wrap;
      idx       <= nidx;
      if (wrap) begin
        sh_v <= bus.value;
        sh_d <= bus.dp_mask;
      end
      if (advance) begin
        an_oh <= an_n;
        seg_r <= seg_n;
        dp_r  <= dpl;
      end
    end
  assign bus.an         = AN_ACTIVE_LOW != 0 ? ~an_act : an_act;
  assign bus.seg        = SEG_ACTIVE_LOW != 0 ? ~seg_r : seg_r;
  assign bus.dp         = SEG_ACTIVE_LOW != 0 ? ~dp_r : dp_r;
  assign bus.digit_idx  = idx;
  assign bus.frame_done = fd;
endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan: scoreboard bench, expected scan steps queued by stimulus and checked by a monitor
module tb_seg_display_scan;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] idx;
    logic       fd;
  } exp_t;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  seg_display_scan_if #(.NUM_DIGITS(4)) bus ();
  seg_display_scan #(.NUM_DIGITS(4), .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tog(input int i, input logic [3:0] n, input logic dl, input logic f,
                     input logic anoff, input logic segoff);
    exp_t e;
    logic [3:0] oh;
    @(negedge clk);
    bus.seg_tick_in = ~bus.seg_tick_in;
    oh     = 4'b0001 << i;
    e.an   = anoff ? 4'hF : ~oh;
    e.seg  = segoff ? 7'h7F : ~tbl[n];
    e.dp   = ~dl;
    e.idx  = 3'(i);
    e.fd   = f;
    q.push_back(e);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [2:0] last = 3'd3;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.digit_idx !== last) begin
          if (q.size() == 0) chk("unexpected_advance", 32'(bus.digit_idx), 32'(last));
          else begin
            e = q.pop_front();
            chk($sformatf("scan_idx%0d{an,seg,dp,idx,fd}", e.idx),
                32'({bus.an, bus.seg, bus.dp, bus.digit_idx, bus.frame_done}), 32'(e));
          end
        end else chk("frame_done_idle", 32'(bus.frame_done), 32'd0);
      end
      last = bus.digit_idx;
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.seg_tick_in = 1'b0;
    bus.value = 16'h1234;
    bus.dp_mask = 4'b0000;
    bus.blank = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_an", 32'(bus.an), 32'hF);
    chk("reset_seg", 32'(bus.seg), 32'h7F);
    chk("reset_dp", 32'(bus.dp), 32'd1);
    chk("reset_idx", 32'(bus.digit_idx), 32'd3);
    chk("reset_fd", 32'(bus.frame_done), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("hold_after_release_an", 32'(bus.an), 32'hF);
    tog(0, 4'h4, 0, 1, 0, 0);
    tog(1, 4'h3, 0, 0, 0, 0);
    tog(2, 4'h2, 0, 0, 0, 0);
    tog(3, 4'h1, 0, 0, 0, 0);
    tog(0, 4'h4, 0, 1, 0, 0);
    tog(1, 4'h3, 0, 0, 0, 0);
    bus.value = 16'hABCD;
    tog(2, 4'h2, 0, 0, 0, 0);
    tog(3, 4'h1, 0, 0, 0, 0);
    tog(0, 4'hD, 0, 1, 0, 0);
    bus.blank = 1'b1;
    @(negedge clk);
    chk("blank_an", 32'(bus.an), 32'hF);
    tog(1, 4'hC, 0, 0, 1, 0);
    tog(2, 4'hB, 0, 0, 1, 0);
    tog(3, 4'hA, 0, 0, 1, 0);
    tog(0, 4'hD, 0, 1, 1, 0);
    tog(1, 4'hC, 0, 0, 1, 0);
    bus.blank = 1'b0;
    @(negedge clk);
    chk("unblank_an", 32'(bus.an), 32'b1101);
    bus.value = 16'h0000;
    bus.dp_mask = 4'b0100;
    tog(2, 4'hB, 0, 0, 0, 0);
    tog(3, 4'hA, 0, 0, 0, 0);
    tog(0, 4'h0, 0, 1, 0, 0);
    tog(1, 4'h0, 0, 0, LZ, LZ);
    tog(2, 4'h0, 1, 0, 0, LZ);
    tog(3, 4'h0, 0, 0, LZ, LZ);
    tog(0, 4'h0, 0, 1, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    bus.seg_tick_in = 1'b0;
    #1;
    chk("async_reset_an", 32'(bus.an), 32'hF);
    chk("async_reset_seg", 32'(bus.seg), 32'h7F);
    chk("async_reset_dp", 32'(bus.dp), 32'd1);
    chk("async_reset_idx", 32'(bus.digit_idx), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_hold_an", 32'(bus.an), 32'hF);
    chk("post_reset_hold_seg", 32'(bus.seg), 32'h7F);
    tog(0, 4'h0, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
